// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16-bit shift-and-add multiplier:
// FSM state encoding and the iteration bound.
package mul16_seq_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ITER_LAST = 4'd15;

endpackage

// File: rtl/mul16_seq_if.sv
// Request/result bundle between the ALU sequencer (master) and mul16_seq (slave).
interface mul16_seq_if;
  import mul16_seq_pkg::*;

  logic                 start;
  logic [MUL_WIDTH-1:0] a;
  logic [MUL_WIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [MUL_WIDTH-1:0] product;

  modport master (output start, a, b, input  busy, done, product);
  modport slave  (input  start, a, b, output busy, done, product);

endinterface

// File: rtl/mul16_seq_add16.sv
// Add16: plain 16-bit adder; the carry-out falls off the top, so sums wrap mod 2^16.
module Add16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-and-add multiplier: low 16 bits of a*b in exactly 16 RUN
// cycles, sharing a single Add16 between the partial product and multiplicand.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mul16_seq_if.slave  bus
);

  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("mul16_seq: only WIDTH=16 is supported");
  end

  state_e      r_state;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic [3:0]  r_count;
  logic [15:0] r_product;

  logic [15:0] w_sum;
  logic [15:0] w_next_acc;

  Add16 u_add16 (
    .i_a   (r_acc),
    .i_b   (r_mcand),
    .o_sum (w_sum)
  );

  assign w_next_acc = r_mplier[0] ? w_sum : r_acc;

  // NOTE: datapath registers are reset along with the FSM so an aborted
  // operation leaves no stale partial product behind; all state uses <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc    <= w_next_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 4'd1;
          if (r_count == ITER_LAST) begin
            r_product <= w_next_acc;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: scoreboard of expected products, latency,
// busy-window, ignore-while-busy, back-to-back and asynchronous-reset scenarios.
module tb_mul16_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul16_seq_if bus ();

  mul16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request from IDLE; returns just after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    exp_q.push_back(16'(a * b));
  endtask

  // Bounded wait for the done pulse; counts edges and busy samples on the way.
  task automatic wait_done(output int edges, output int busy_cnt, output bit seen);
    edges = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      step();
      edges++;
    end
  endtask

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", bus.product); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b);
    int edges, busy_cnt; bit seen; logic [15:0] exp;
    start_op(a, b);
    wait_done(edges, busy_cnt, seen);
    exp = pop_exp();
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout no done within 40 edges", name); end
    checks++; if (edges !== 16) begin errors++; $display("FAIL %s_latency got %0d edges after accept want 16 (17 cycles)", name, edges); end
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL %s_busy_cycles got %0d want 16", name, busy_cnt); end
    checks++; if (bus.product !== exp) begin errors++; $display("FAIL %s_product got %h want %h", name, bus.product, exp); end
    step();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s_after_done done=%b busy=%b want 0/0", name, bus.done, bus.busy); end
    checks++; if (bus.product !== exp) begin errors++; $display("FAIL %s_product_hold got %h want %h", name, bus.product, exp); end
  endtask

  task automatic test_basic();
    run_one("basic_3x5", 16'd3, 16'd5);
  endtask

  task automatic test_wrap();
    run_one("wrap_ffff", 16'hFFFF, 16'hFFFF);
    run_one("wrap_0100", 16'h0100, 16'h0100);
  endtask

  task automatic test_zero_identity();
    run_one("zero", 16'h0000, 16'hFFFF);
    run_one("identity", 16'hABCD, 16'h0001);
  endtask

  task automatic test_ignore_busy();
    int edges, busy_cnt, extra_done, extra_busy; bit seen; logic [15:0] exp;
    start_op(16'd7, 16'd6);
    repeat (5) step();
    bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
    step();
    bus.start = 1'b0;
    wait_done(edges, busy_cnt, seen);
    exp = pop_exp();
    checks++; if (!seen) begin errors++; $display("FAIL ignore_timeout no done within bound"); end
    checks++; if (edges + 6 !== 16) begin errors++; $display("FAIL ignore_latency got %0d edges want 16", edges + 6); end
    checks++; if (bus.product !== exp) begin errors++; $display("FAIL ignore_product got %h want %h", bus.product, exp); end
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
    end
    checks++; if (extra_done !== 0 || extra_busy !== 0) begin errors++; $display("FAIL ignore_second_op done=%0d busy=%0d cycles want 0/0", extra_done, extra_busy); end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cnt; bit seen; logic [15:0] exp;
    bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd3;
    step();
    exp_q.push_back(16'h0006);
    bus.a = 16'h1234; bus.b = 16'h0001;
    exp_q.push_back(16'h1234);
    wait_done(edges, busy_cnt, seen);
    exp = pop_exp();
    checks++; if (!seen || edges !== 16) begin errors++; $display("FAIL b2b_first_latency seen=%b edges=%0d want 1/16", seen, edges); end
    checks++; if (bus.product !== exp) begin errors++; $display("FAIL b2b_first_product got %h want %h", bus.product, exp); end
    step();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_reaccept busy=%b done=%b want 1/0", bus.busy, bus.done); end
    repeat (8) step();
    checks++; if (bus.product !== 16'h0006) begin errors++; $display("FAIL b2b_product_hold got %h want 0006", bus.product); end
    wait_done(edges, busy_cnt, seen);
    exp = pop_exp();
    checks++; if (!seen || edges + 9 !== 17) begin errors++; $display("FAIL b2b_spacing seen=%b got %0d edges between done pulses want 17", seen, edges + 9); end
    checks++; if (bus.product !== exp) begin errors++; $display("FAIL b2b_second_product got %h want %h", bus.product, exp); end
    step();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle done=%b busy=%b want 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0101;
    step();
    bus.start = 1'b0;
    repeat (8) step();
    checks++; if (bus.busy !== 1'b1 || bus.product === 16'h0000) begin errors++; $display("FAIL midrun_precond busy=%b product=%h want busy 1 product nonzero", bus.busy, bus.product); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrun_async busy=%b done=%b want 0/0", bus.busy, bus.done); end
    checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL midrun_product got %h want 0000", bus.product); end
    repeat (2) step();
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done || bus.busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrun_no_done got %0d active cycles want 0", dones); end
    run_one("after_reset_4x4", 16'd4, 16'd4);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_identity();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
